// File: rtl/apb_arb_pkg.sv
// Shared types and the tie-break helper for the two-initiator APB arbiter.
package apb_arb_pkg;

  localparam int ARB_N_REQ = 2;

  typedef enum logic [1:0] {ARB_IDLE, ARB_SETUP, ARB_ACCESS} arb_state_t;

  // Picks the requester to grant from IDLE; a tie goes to ~last (round-robin) or to 0 (fixed).
  function automatic logic arb_pick(input logic [ARB_N_REQ-1:0] req,
                                    input logic                 last,
                                    input logic                 fixed);
    logic pick;
    if (req == 2'b11) begin
      pick = fixed ? 1'b0 : ~last;
    end else if (req[1]) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/apb_arbiter_chk.sv
// Protocol checker for the arbiter's fabric-side and response signals.
module apb_arbiter_chk (
  input logic        clk,
  input logic        rst_n,
  input logic        f_psel,
  input logic        f_penable,
  input logic        f_pready,
  input logic [31:0] f_paddr,
  input logic        r0_pready,
  input logic        r1_pready
);

  // Access phase must follow a cycle with select asserted.
  a_penable_after_psel: assert property (@(posedge clk) disable iff (!rst_n)
    f_penable |-> $past(f_psel));

  // Address must not move while the fabric is holding off the transfer.
  a_paddr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (f_psel && !f_pready) |=> $stable(f_paddr));

  // At most one requester is completed per cycle.
  a_pready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({r0_pready, r1_pready}));

endmodule

// File: rtl/apb_arbiter.sv
// Two-initiator APB arbiter: serialises r0/r1 transfers onto one fabric port,
// re-issuing each as a fresh SETUP/ACCESS sequence and routing the completion back.
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_psel,
  input  logic        r0_penable,
  output logic        r0_pready,
  input  logic [31:0] r0_paddr,
  input  logic        r0_pwrite,
  input  logic [31:0] r0_pwdata,
  input  logic [3:0]  r0_pwstrb,
  output logic [31:0] r0_prdata,
  output logic        r0_pslverr,
  input  logic        r1_psel,
  input  logic        r1_penable,
  output logic        r1_pready,
  input  logic [31:0] r1_paddr,
  input  logic        r1_pwrite,
  input  logic [31:0] r1_pwdata,
  input  logic [3:0]  r1_pwstrb,
  output logic [31:0] r1_prdata,
  output logic        r1_pslverr,
  output logic        f_psel,
  output logic        f_penable,
  input  logic        f_pready,
  output logic [31:0] f_paddr,
  output logic        f_pwrite,
  output logic [31:0] f_pwdata,
  output logic [3:0]  f_pwstrb,
  input  logic [31:0] f_prdata,
  input  logic        f_pslverr
);

  localparam logic FIXED = (FIXED_PRIO != 0);

  arb_state_t           r_state;
  logic                 r_gnt;
  logic                 r_last;
  logic                 r_psel;
  logic                 r_penable;

  logic [ARB_N_REQ-1:0] w_req;
  logic                 w_other_req;
  logic                 w_done;
  logic                 w_unused;

  assign w_req       = {r1_psel, r0_psel};
  // The finished requester's psel still belongs to its old transfer, so only the other one counts.
  assign w_other_req = r_gnt ? r0_psel : r1_psel;
  assign w_done      = (r_state == ARB_ACCESS) && f_pready;
  assign w_unused    = &{1'b0, r0_penable, r1_penable};

  // Arbitration FSM with registered fabric select/enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ARB_IDLE;
      r_gnt     <= 1'b0;
      r_last    <= 1'b1;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_req != 2'b00) begin
            r_gnt     <= arb_pick(w_req, r_last, FIXED);
            r_state   <= ARB_SETUP;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
          end
        end
        ARB_SETUP: begin
          r_state   <= ARB_ACCESS;
          r_penable <= 1'b1;
        end
        ARB_ACCESS: begin
          if (f_pready) begin
            r_last <= r_gnt;
            if (w_other_req) begin
              r_gnt     <= ~r_gnt;
              r_state   <= ARB_SETUP;
              r_penable <= 1'b0;
            end else begin
              r_state   <= ARB_IDLE;
              r_psel    <= 1'b0;
              r_penable <= 1'b0;
            end
          end
        end
        default: begin
          r_state   <= ARB_IDLE;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

  // Request mux toward the fabric; zeroed while idle.
  always_comb begin
    f_paddr  = 32'h0;
    f_pwrite = 1'b0;
    f_pwdata = 32'h0;
    f_pwstrb = 4'h0;
    if (r_state == ARB_IDLE) begin
      f_paddr  = 32'h0;
    end else if (r_gnt) begin
      f_paddr  = r1_paddr;
      f_pwrite = r1_pwrite;
      f_pwdata = r1_pwdata;
      f_pwstrb = r1_pwstrb;
    end else begin
      f_paddr  = r0_paddr;
      f_pwrite = r0_pwrite;
      f_pwdata = r0_pwdata;
      f_pwstrb = r0_pwstrb;
    end
  end

  assign f_psel     = r_psel;
  assign f_penable  = r_penable;

  assign r0_pready  = w_done && !r_gnt;
  assign r1_pready  = w_done && r_gnt;
  assign r0_pslverr = w_done && !r_gnt && f_pslverr;
  assign r1_pslverr = w_done && r_gnt && f_pslverr;
  assign r0_prdata  = f_prdata;
  assign r1_prdata  = f_prdata;

endmodule

// File: tb/tb_apb_arbiter.sv
// Scoreboard bench: instance 0 is round-robin, instance 1 is fixed priority.
module tb_apb_arbiter;

  localparam logic [31:0] KEY = 32'hC0DE_0000;

  typedef struct {
    int          inst;
    int          id;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        psel [2][2], penable [2][2], pwrite [2][2], pready [2][2], pslverr [2][2];
  logic [31:0] paddr [2][2], pwdata [2][2], prdata [2][2];
  logic [3:0]  pwstrb [2][2];
  logic        f_psel [2], f_penable [2], f_pwrite [2], f_pready [2], f_pslverr [2];
  logic [31:0] f_paddr [2], f_pwdata [2], f_prdata [2];
  logic [3:0]  f_pwstrb [2];

  int          n_vec = 0;
  int          n_err = 0;
  int          fab_waits = 0;
  logic        fab_err = 1'b0;
  logic [31:0] fab_key = KEY;
  exp_t        exp_q [$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    apb_arbiter #(.FIXED_PRIO(g)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .r0_psel(psel[g][0]), .r0_penable(penable[g][0]), .r0_pready(pready[g][0]),
      .r0_paddr(paddr[g][0]), .r0_pwrite(pwrite[g][0]), .r0_pwdata(pwdata[g][0]),
      .r0_pwstrb(pwstrb[g][0]), .r0_prdata(prdata[g][0]), .r0_pslverr(pslverr[g][0]),
      .r1_psel(psel[g][1]), .r1_penable(penable[g][1]), .r1_pready(pready[g][1]),
      .r1_paddr(paddr[g][1]), .r1_pwrite(pwrite[g][1]), .r1_pwdata(pwdata[g][1]),
      .r1_pwstrb(pwstrb[g][1]), .r1_prdata(prdata[g][1]), .r1_pslverr(pslverr[g][1]),
      .f_psel(f_psel[g]), .f_penable(f_penable[g]), .f_pready(f_pready[g]),
      .f_paddr(f_paddr[g]), .f_pwrite(f_pwrite[g]), .f_pwdata(f_pwdata[g]),
      .f_pwstrb(f_pwstrb[g]), .f_prdata(f_prdata[g]), .f_pslverr(f_pslverr[g])
    );
    apb_arbiter_chk u_chk (
      .clk(clk), .rst_n(rst_n), .f_psel(f_psel[g]), .f_penable(f_penable[g]),
      .f_pready(f_pready[g]), .f_paddr(f_paddr[g]),
      .r0_pready(pready[g][0]), .r1_pready(pready[g][1])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, want);
    end
  endtask

  task automatic expect_xfer(input int inst, input int id, input logic [31:0] a,
                             input logic [31:0] rd, input logic err);
    exp_t e;
    e.inst = inst; e.id = id; e.addr = a; e.rdata = rd; e.err = err;
    exp_q.push_back(e);
  endtask

  // Setup on one negedge, access on the next, then wait (bounded) for this requester's pready.
  task automatic req_xfer(input int inst, input int id, input logic [31:0] a, input logic w,
                          input logic [31:0] d, input logic [3:0] s);
    bit done;
    done = 1'b0;
    @(negedge clk);
    psel[inst][id] = 1'b1; penable[inst][id] = 1'b0; paddr[inst][id] = a;
    pwrite[inst][id] = w; pwdata[inst][id] = d; pwstrb[inst][id] = s;
    @(negedge clk);
    penable[inst][id] = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk); #1;
      done = (pready[inst][id] === 1'b1);
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL pready_timeout: inst %0d r%0d got no pready in 100 cycles, want pready", inst, id);
    end
  endtask

  task automatic req_release(input int inst, input int id);
    @(negedge clk);
    psel[inst][id] = 1'b0; penable[inst][id] = 1'b0;
  endtask

  task automatic lone(input int inst, input int id, input logic [31:0] a);
    expect_xfer(inst, id, a, a ^ KEY, 1'b0);
    req_xfer(inst, id, a, 1'b0, 32'h0, 4'h0);
    req_release(inst, id);
  endtask

  task automatic tie(input int inst, input logic [31:0] a0, input logic [31:0] a1, input int first);
    logic [31:0] a_second;
    a_second = (first == 0) ? a1 : a0;
    if (first == 0) begin
      expect_xfer(inst, 0, a0, a0 ^ KEY, 1'b0);
      expect_xfer(inst, 1, a1, a1 ^ KEY, 1'b0);
    end else begin
      expect_xfer(inst, 1, a1, a1 ^ KEY, 1'b0);
      expect_xfer(inst, 0, a0, a0 ^ KEY, 1'b0);
    end
    fork
      begin req_xfer(inst, 0, a0, 1'b0, 32'h0, 4'h0); req_release(inst, 0); end
      begin req_xfer(inst, 1, a1, 1'b0, 32'h0, 4'h0); req_release(inst, 1); end
      begin
        bit hit;
        hit = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
          @(negedge clk); #1;
          hit = (pready[inst][0] === 1'b1) || (pready[inst][1] === 1'b1);
        end
        @(negedge clk); #1;
        chk("tie_no_bubble_psel", 32'(f_psel[inst]), 32'd1);
        chk("tie_no_bubble_penable", 32'(f_penable[inst]), 32'd0);
        chk("tie_second_addr", f_paddr[inst], a_second);
      end
    join
  endtask

  // Fabric model: pready after fab_waits ACCESS cycles; junk on response lines outside ACCESS.
  initial begin
    int cnt [2];
    for (int g = 0; g < 2; g++) begin
      cnt[g] = 0; f_pready[g] = 1'b1; f_pslverr[g] = 1'b1; f_prdata[g] = 32'h5A5A_5A5A;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (f_psel[g] && f_penable[g]) begin
          f_pready[g]  = (cnt[g] >= fab_waits);
          f_pslverr[g] = fab_err;
          f_prdata[g]  = f_paddr[g] ^ fab_key;
          cnt[g]++;
        end else begin
          cnt[g] = 0; f_pready[g] = 1'b1; f_pslverr[g] = 1'b1; f_prdata[g] = 32'h5A5A_5A5A;
        end
      end
    end
  end

  // Monitor: every completion pops the next expected transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      for (int g = 0; g < 2; g++) begin
        for (int r = 0; r < 2; r++) begin
          if (pready[g][r] === 1'b1) begin
            if (exp_q.size() == 0) begin
              n_vec++; n_err++;
              $display("FAIL spurious_pready: inst %0d r%0d got pready=1, want none", g, r);
            end else begin
              e = exp_q.pop_front();
              chk("grant_inst", 32'(g), 32'(e.inst));
              chk("grant_id", 32'(r), 32'(e.id));
              chk("f_paddr", f_paddr[g], e.addr);
              chk("prdata", prdata[g][r], e.rdata);
              chk("pslverr", 32'(pslverr[g][r]), 32'(e.err));
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      for (int r = 0; r < 2; r++) begin
        psel[g][r] = 1'b0; penable[g][r] = 1'b0; paddr[g][r] = 32'h0;
        pwrite[g][r] = 1'b0; pwdata[g][r] = 32'h0; pwstrb[g][r] = 4'h0;
      end
    end
    repeat (3) @(negedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("rst_f_psel", 32'(f_psel[g]), 32'd0);
      chk("rst_f_penable", 32'(f_penable[g]), 32'd0);
      chk("rst_f_paddr", f_paddr[g], 32'h0);
      chk("rst_pready", 32'({pready[g][1], pready[g][0]}), 32'd0);
      chk("rst_pslverr", 32'({pslverr[g][1], pslverr[g][0]}), 32'd0);
    end
    rst_n = 1'b1;

    // First tie after reset goes to r0, then r1 with no idle cycle; repeat tie again favours r0.
    tie(0, 32'h4000_0000, 32'h4100_0000, 0);
    tie(0, 32'h4000_0010, 32'h4100_0010, 0);

    // Single 0-wait read with exact cycle positions.
    fab_key = 32'h5EAD_BEFF;
    expect_xfer(0, 0, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    psel[0][0] = 1'b1; penable[0][0] = 1'b0; paddr[0][0] = 32'h8000_0010; pwrite[0][0] = 1'b0;
    #1 chk("t1_cycle1_f_psel", 32'(f_psel[0]), 32'd0);
    @(negedge clk); #1;
    chk("t1_cycle2_f_psel", 32'(f_psel[0]), 32'd1);
    chk("t1_cycle2_f_penable", 32'(f_penable[0]), 32'd0);
    penable[0][0] = 1'b1;
    @(negedge clk); #1;
    chk("t1_cycle3_f_penable", 32'(f_penable[0]), 32'd1);
    chk("t1_cycle3_r0_pready", 32'(pready[0][0]), 32'd1);
    chk("t1_cycle3_r0_prdata", prdata[0][0], 32'hDEAD_BEEF);
    @(negedge clk);
    psel[0][0] = 1'b0; penable[0][0] = 1'b0;
    #1 chk("t1_back_to_idle", 32'(f_psel[0]), 32'd0);
    fab_key = KEY;
    repeat (2) @(negedge clk);

    // r0 served last, so the next tie goes to r1.
    tie(0, 32'h4200_0000, 32'h4300_0000, 1);

    // r1 write with 4 wait states ending in an error.
    fab_waits = 4; fab_err = 1'b1;
    expect_xfer(0, 1, 32'h1000_0000, 32'h1000_0000 ^ KEY, 1'b1);
    fork
      begin req_xfer(0, 1, 32'h1000_0000, 1'b1, 32'hA5A5_1234, 4'b0011); req_release(0, 1); end
      begin
        int  errs;
        bit  seen;
        errs = 0; seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
          @(negedge clk); #1;
          seen = f_penable[0];
        end
        for (int c = 0; c < 5; c++) begin
          if (c > 0) begin @(negedge clk); #1; end
          chk("t6_f_penable", 32'(f_penable[0]), 32'd1);
          chk("t6_f_pwdata", f_pwdata[0], 32'hA5A5_1234);
          chk("t6_f_pwstrb", 32'(f_pwstrb[0]), 32'h3);
          chk("t6_r0_pready", 32'(pready[0][0]), 32'd0);
          errs += int'(pslverr[0][1]);
        end
        @(negedge clk); #1;
        errs += int'(pslverr[0][1]);
        chk("t6_f_penable_after", 32'(f_penable[0]), 32'd0);
        chk("t6_pslverr_pulses", 32'(errs), 32'd1);
      end
    join
    fab_waits = 0; fab_err = 1'b0;
    repeat (2) @(negedge clk);

    // Leave last=0, then reset while the fabric stalls an r0 access.
    lone(0, 0, 32'h2000_0004);
    fab_waits = 50;
    @(negedge clk);
    psel[0][0] = 1'b1; penable[0][0] = 1'b0; paddr[0][0] = 32'h3000_0000; pwrite[0][0] = 1'b0;
    @(negedge clk);
    penable[0][0] = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk("t7_stalled_access", 32'(f_penable[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("t7_rst_f_psel", 32'(f_psel[0]), 32'd0);
    chk("t7_rst_f_penable", 32'(f_penable[0]), 32'd0);
    chk("t7_rst_pready", 32'({pready[0][1], pready[0][0]}), 32'd0);
    psel[0][0] = 1'b0; penable[0][0] = 1'b0;
    rst_n = 1'b1; fab_waits = 0;
    tie(0, 32'h3000_0100, 32'h3100_0100, 0);

    // Fixed priority: after a lone r0 a tie still goes to r0; r0 re-requests alternate with r1.
    lone(1, 0, 32'h5000_0000);
    tie(1, 32'h5000_0010, 32'h5100_0010, 0);
    expect_xfer(1, 0, 32'h6000_0000, 32'h6000_0000 ^ KEY, 1'b0);
    expect_xfer(1, 1, 32'h6100_0000, 32'h6100_0000 ^ KEY, 1'b0);
    expect_xfer(1, 0, 32'h6000_0004, 32'h6000_0004 ^ KEY, 1'b0);
    fork
      begin
        req_xfer(1, 0, 32'h6000_0000, 1'b1, 32'h1111_1111, 4'hF);
        req_xfer(1, 0, 32'h6000_0004, 1'b1, 32'h2222_2222, 4'hF);
        req_release(1, 0);
      end
      begin req_xfer(1, 1, 32'h6100_0000, 1'b0, 32'h0, 4'h0); req_release(1, 1); end
    join

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
